// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle: fetch requester, data requester and memory side.
// The arbiter takes the slave view; the requesters and memory take the master view.
interface mem_port_arbiter_if;
    logic        getir_istek_i;
    logic [31:0] getir_adres_i;
    logic        getir_iptal_i;
    logic        getir_gecerli_o;
    logic [31:0] getir_deger_o;

    logic        veri_istek_i;
    logic        veri_yaz_i;
    logic [31:0] veri_adres_i;
    logic [31:0] veri_yaz_deger_i;
    logic [3:0]  veri_maske_i;
    logic        veri_gecerli_o;
    logic [31:0] veri_deger_o;

    logic        bellek_istek_o;
    logic        bellek_yaz_o;
    logic [31:0] bellek_adres_o;
    logic [31:0] bellek_yaz_deger_o;
    logic [3:0]  bellek_maske_o;
    logic        bellek_hazir_i;
    logic        bellek_gecerli_i;
    logic [31:0] bellek_deger_i;

    modport slave (
        input  getir_istek_i, getir_adres_i, getir_iptal_i,
        output getir_gecerli_o, getir_deger_o,
        input  veri_istek_i, veri_yaz_i, veri_adres_i,
        input  veri_yaz_deger_i, veri_maske_i,
        output veri_gecerli_o, veri_deger_o,
        output bellek_istek_o, bellek_yaz_o, bellek_adres_o,
        output bellek_yaz_deger_o, bellek_maske_o,
        input  bellek_hazir_i, bellek_gecerli_i, bellek_deger_i
    );

    modport master (
        output getir_istek_i, getir_adres_i, getir_iptal_i,
        input  getir_gecerli_o, getir_deger_o,
        output veri_istek_i, veri_yaz_i, veri_adres_i,
        output veri_yaz_deger_i, veri_maske_i,
        input  veri_gecerli_o, veri_deger_o,
        input  bellek_istek_o, bellek_yaz_o, bellek_adres_o,
        input  bellek_yaz_deger_o, bellek_maske_o,
        output bellek_hazir_i, bellek_gecerli_i, bellek_deger_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction
// fetch and load/store, data-priority with a bounded fetch starvation window.
module mem_port_arbiter #(
    parameter int AC_SINIR = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        BOS,
        ISTEK,
        BEKLE,
        YANIT
    } durum_e;

    localparam logic [2:0] SINIR = 3'(AC_SINIR);

    durum_e      durum_q, durum_d;
    logic        sahip_getir_q, sahip_getir_d;
    logic [31:0] adres_q, adres_d;
    logic        yaz_q, yaz_d;
    logic [31:0] yaz_deger_q, yaz_deger_d;
    logic [3:0]  maske_q, maske_d;
    logic [2:0]  sayac_q, sayac_d;
    logic        iptal_q, iptal_d;
    logic [31:0] getir_deger_q, getir_deger_d;
    logic [31:0] veri_deger_q, veri_deger_d;

    logic        getir_kazanir;
    logic        yanit_al;

    always_comb begin
        durum_d       = durum_q;
        sahip_getir_d = sahip_getir_q;
        adres_d       = adres_q;
        yaz_d         = yaz_q;
        yaz_deger_d   = yaz_deger_q;
        maske_d       = maske_q;
        sayac_d       = sayac_q;
        iptal_d       = iptal_q;
        getir_deger_d = getir_deger_q;
        veri_deger_d  = veri_deger_q;
        getir_kazanir = 1'b0;
        yanit_al      = 1'b0;

        unique case (durum_q)
            BOS: begin
                if (!bus.getir_istek_i) begin
                    sayac_d = 3'd0;
                end
                if (bus.getir_istek_i || bus.veri_istek_i) begin
                    // Fetch only wins when data is idle or the window is spent.
                    getir_kazanir = bus.getir_istek_i &&
                                    (!bus.veri_istek_i || sayac_q >= SINIR);
                    durum_d       = ISTEK;
                    iptal_d       = 1'b0;
                    sahip_getir_d = getir_kazanir;
                    if (getir_kazanir) begin
                        adres_d     = bus.getir_adres_i;
                        yaz_d       = 1'b0;
                        yaz_deger_d = 32'd0;
                        maske_d     = 4'b0000;
                        sayac_d     = 3'd0;
                    end else begin
                        adres_d     = bus.veri_adres_i;
                        yaz_d       = bus.veri_yaz_i;
                        yaz_deger_d = bus.veri_yaz_deger_i;
                        maske_d     = bus.veri_maske_i;
                        if (bus.getir_istek_i && sayac_q < SINIR) begin
                            sayac_d = sayac_q + 3'd1;
                        end
                    end
                end
            end
            ISTEK: begin
                if (sahip_getir_q && bus.getir_iptal_i) begin
                    iptal_d = 1'b1;
                end
                if (bus.bellek_hazir_i) begin
                    if (bus.bellek_gecerli_i) begin
                        yanit_al = 1'b1;
                        durum_d  = YANIT;
                    end else begin
                        durum_d  = BEKLE;
                    end
                end
            end
            BEKLE: begin
                if (sahip_getir_q && bus.getir_iptal_i) begin
                    iptal_d = 1'b1;
                end
                if (bus.bellek_gecerli_i) begin
                    yanit_al = 1'b1;
                    durum_d  = YANIT;
                end
            end
            YANIT: begin
                durum_d = BOS;
            end
        endcase

        if (yanit_al) begin
            if (sahip_getir_q) begin
                getir_deger_d = bus.bellek_deger_i;
            end else if (!yaz_q) begin
                veri_deger_d = bus.bellek_deger_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            durum_q       <= BOS;
            sahip_getir_q <= 1'b0;
            adres_q       <= 32'd0;
            yaz_q         <= 1'b0;
            yaz_deger_q   <= 32'd0;
            maske_q       <= 4'b0000;
            sayac_q       <= 3'd0;
            iptal_q       <= 1'b0;
            getir_deger_q <= 32'd0;
            veri_deger_q  <= 32'd0;
        end else begin
            durum_q       <= durum_d;
            sahip_getir_q <= sahip_getir_d;
            adres_q       <= adres_d;
            yaz_q         <= yaz_d;
            yaz_deger_q   <= yaz_deger_d;
            maske_q       <= maske_d;
            sayac_q       <= sayac_d;
            iptal_q       <= iptal_d;
            getir_deger_q <= getir_deger_d;
            veri_deger_q  <= veri_deger_d;
        end
    end

    assign bus.bellek_istek_o     = (durum_q == ISTEK);
    assign bus.bellek_yaz_o       = yaz_q;
    assign bus.bellek_adres_o     = adres_q;
    assign bus.bellek_yaz_deger_o = yaz_deger_q;
    assign bus.bellek_maske_o     = maske_q;

    // A redirect in the response cycle itself still kills the strobe.
    assign bus.getir_gecerli_o = (durum_q == YANIT) && sahip_getir_q &&
                                 !iptal_q && !bus.getir_iptal_i;
    assign bus.veri_gecerli_o  = (durum_q == YANIT) && !sahip_getir_q;
    assign bus.getir_deger_o   = getir_deger_q;
    assign bus.veri_deger_o    = veri_deger_q;

endmodule
